// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, captures instruction memory words into a valid/ready slot for decode,
// with redirect, halt and out-of-range fault handling; FETCH_PERF_EN adds saturating fetch/stall counters.
module instruction_fetch #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          MEM_DEPTH   = 128,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        halted,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   output logic        fault
);
   typedef enum logic [1:0] {S_FETCH, S_HALTED, S_FAULT} state_t;
   localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d;
   logic        valid_q, valid_d, slot_free, in_range, capture;
   assign slot_free = !valid_q || out_ready;
   assign in_range  = {1'b0, pc_q} < DEPTH;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      valid_d = valid_q;
      capture = 1'b0;
      // redirect beats capture, stall and halt detection; a faulted fetcher ignores it
      if (state_q != S_FAULT && redirect_valid) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         state_d = S_FETCH;
      end else if (state_q == S_FETCH && slot_free) begin
         if (in_range) begin
            capture = 1'b1;
            instr_d = imem_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd1;
            state_d = imem_instr[15:12] == HALT_OPCODE ? S_HALTED : S_FETCH;
         end else begin
            valid_d = 1'b0;
            state_d = S_FAULT;
         end
      end else if (state_q == S_HALTED && out_ready) begin
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         opc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         valid_q <= valid_d;
      end
   end
   assign imem_addr = pc_q;
   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_pc    = opc_q;
   assign halted    = state_q == S_HALTED;
   assign fault     = state_q == S_FAULT;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;
   logic        stall;
   assign stall = state_q == S_FETCH && valid_q && !out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (capture && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side master of the 16-bit instruction memory. It owns the program counter (PC), drives the memory address, and captures the combinational read data into a registered instruction slot.
- Hands each instruction plus its PC to decode through a valid/ready handshake.
- Supports control-flow redirect, halt-opcode detection and an out-of-range fetch fault.
- Sits between the instruction memory (combinational read, 16-bit words, locations from 0) and the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_DEPTH, 128, number of valid instruction words; a fetch from an address >= MEM_DEPTH faults.
- HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  16  address to instruction memory; equals pc register (combinational from pc).
- imem_instr  input  16  instruction word returned combinationally for imem_addr.
- out_valid  output  1  out_instr/out_pc hold an instruction for decode.
- out_ready  input  1  decode accepts when out_valid && out_ready at a rising edge.
- out_instr  output  16  registered instruction.
- out_pc  output  16  address out_instr was fetched from.
- redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  16  new fetch address.
- halted  output  1  high while in HALTED.
- fault  output  1  sticky out-of-range fault flag.

Behaviour:
- Reset (rst=1 at an edge) sets pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, state=FETCH. Reset overrides every other input, in any state, including mid-stall.
- States: FETCH, HALTED, FAULT (2-bit encoded).
- slot_free = !out_valid || out_ready.
- FETCH, slot_free, pc < MEM_DEPTH: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1 (16-bit, modulo 2^16).
  - If imem_instr[15:12]==HALT_OPCODE, next state is HALTED. The halt instruction is still presented with out_valid=1 until it is accepted.
- FETCH, slot_free, pc >= MEM_DEPTH: no capture, out_valid<=0, fault<=1, next state FAULT.
- FETCH, !slot_free (stall): pc, out_instr, out_pc and out_valid are all held. The outputs must stay stable while out_valid && !out_ready.
- Latency: one instruction per cycle while out_ready=1. The first out_valid=1 appears one edge after rst deasserts, carrying the word at RESET_PC.
- HALTED: halted=1 and no fetch. out_valid clears when the pending instruction is accepted and stays 0 thereafter.
- FAULT: out_valid=0 and fault=1. Only rst leaves FAULT; redirect is ignored.
- Redirect (FETCH or HALTED, redirect_valid=1): pc<=redirect_pc, out_valid<=0 (the pending instruction is dropped even if out_ready=1 that cycle), halted<=0, state FETCH.
  - The redirect target is fetched on the following cycle.
  - A redirect has priority over capture, stall and halt detection in the same cycle.
- The range check applies to redirect_pc only when it is fetched, not when it is loaded.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every capture.
  - perf_stall_cnt increments on every FETCH-state cycle with out_valid && !out_ready.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch: memory holds 0001, 0100, 1590, 1902; rst for 2 cycles, out_ready=1 -> out_valid=1 from cycle 1; out_instr sequence 0001, 0100, 1590, 1902; out_pc 0, 1, 2, 3.
- Stall: hold out_ready=0 for 3 cycles while out_instr=1590 -> out_instr=1590, out_pc=2 and imem_addr=3 are stable; fetch resumes with 1902 the cycle after ready returns.
- Redirect with pending instruction: redirect_valid, redirect_pc=5 while out_valid=1 and out_ready=1 -> next cycle out_valid=0; the cycle after, out_pc=5 and out_instr=mem[5].
- Halt: mem[4]=F000 -> F000 is delivered, halted=1, imem_addr stays 5 and no further out_valid; a later redirect to 0 clears halted and delivers 0001.
- Fault: redirect to 127 (word 3109) -> 3109 is delivered with out_pc=127; next fetch at 128 sets fault=1 with out_valid=0; redirect is ignored; rst clears fault and restarts at 0.
- Reset mid-stall: rst=1 while out_valid=1 and out_ready=0 -> next edge out_valid=0, pc=0, all outputs at reset values.
